vec_mem_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the 512x32 vector memory: 16-word (512-bit) block read/write.

---
 rtl/vec_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_vec_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_arbiter.sv
// Round-robin arbiter and sequencer for the 512x32 vector memory.
// Accepts one 16-word block read or write at a time from N_REQ requesters.
// It drives the memory port and returns a completion pulse, plus read data for reads.
// A base address above MAX_BASE would run past the top of the array.
// Such a command is rejected with resp_err and never touches the memory.
//
// state | meaning
// IDLE  | arbitrate; on a win pulse gnt and latch the command
// ISSUE | memory address/write presented for one cycle
// WAIT  | read only: capture the block the memory registered at end of ISSUE
// DONE  | command retired; completion pulse follows on the next edge
module vec_mem_arbiter #(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 512,
  parameter int MAX_BASE = 496
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          resp_valid,
  output logic                      resp_err,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wr_data,
  input  logic [DATA_W-1:0]         mem_rd_data
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W-1:0] MAX_BASE_A = ADDR_W'(MAX_BASE);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_last_q, rr_last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;

  logic                found;
  logic [IDX_W-1:0]    win;
  int                  cand;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Round-robin pick: first pending request strictly after the last winner
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(rr_last_q) + k) % N_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
    sel_addr  = req_addr[win*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[win*DATA_W +: DATA_W];
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    idx_d         = idx_q;
    we_d          = we_q;
    err_d         = err_q;
    gnt_d         = '0;
    resp_valid_d  = '0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    mem_wr_data_d = mem_wr_data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d     = N_REQ'(1) << win;
          rr_last_d = win;
          idx_d     = win;
          we_d      = req_we[win];
          if (sel_addr > MAX_BASE_A) begin
            // Out-of-range block: retire immediately, memory port untouched
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d      = 1'b0;
            state_d    = ISSUE;
            mem_addr_d = sel_addr;
            mem_we_d   = req_we[win];
            if (req_we[win]) begin
              mem_wr_data_d = sel_wdata;
            end
          end
        end
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        resp_rdata_d = mem_rd_data;
        state_d      = DONE;
      end
      DONE: begin
        resp_valid_d[idx_q] = 1'b1;
        resp_err_d          = err_q;
        state_d             = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight command
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_last_q     <= LAST_IDX;
      idx_q         <= '0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      gnt_q         <= '0;
      resp_valid_q  <= '0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      idx_q         <= idx_d;
      we_q          <= we_d;
      err_q         <= err_d;
      gnt_q         <= gnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Testbench for vec_mem_arbiter.
// A model predicts grants, memory writes and responses from the arbitration and latency rules.
// A monitor compares what the DUT presents against those predictions.
module tb_vec_mem_arbiter;

  localparam int N_REQ    = 2;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 512;
  localparam int MAX_BASE = 496;

  typedef struct {logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;} op_t;
  typedef struct {int idx; int cyc;} gexp_t;
  typedef struct {int idx; logic err; logic we; logic [DATA_W-1:0] rdata; int cyc;} rexp_t;

  logic                    clock;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        resp_valid;
  logic                    resp_err;
  logic [DATA_W-1:0]       resp_rdata;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wr_data;
  logic [DATA_W-1:0]       mem_rd_data;

  vec_mem_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BASE(MAX_BASE)) dut (
    .clock(clock), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory array behind the port, and the model's independent copy
  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
  end

  always @(negedge clock) begin
    if (mem_we) begin
      for (int k = 0; k < 16; k++) begin
        if (int'(mem_addr) + k < 512) mem[int'(mem_addr) + k] <= mem_wr_data[k*32 +: 32];
      end
    end
  end

  always @(posedge clock) begin
    for (int k = 0; k < 16; k++) begin
      mem_rd_data[k*32 +: 32] <= mem[(int'(mem_addr) + k) % 512];
    end
  end

  op_t   pend0[$];
  op_t   pend1[$];
  gexp_t gq[$];
  rexp_t rq[$];

  int                m_busy;
  int                m_rr;
  int                exp_we_cyc;
  logic [ADDR_W-1:0] exp_we_addr;
  logic [DATA_W-1:0] exp_we_data;

  // Reference model: round-robin winner, fixed latencies, block memory contents
  always @(posedge clock or negedge reset) begin : model
    int win;
    int cand;
    int a;
    int lat;
    logic we;
    logic err;
    logic [DATA_W-1:0] blk;
    if (!reset) begin
      m_busy     = 0;
      m_rr       = N_REQ - 1;
      exp_we_cyc = -1;
      gq.delete();
      rq.delete();
    end else begin
      cyc++;
      if (m_busy > 0) begin
        m_busy--;
      end else if (req != '0) begin
        win = -1;
        for (int k = 1; k <= N_REQ; k++) begin
          cand = (m_rr + k) % N_REQ;
          if (win < 0 && req[cand]) win = cand;
        end
        m_rr = win;
        a    = int'(req_addr[win*ADDR_W +: ADDR_W]);
        we   = req_we[win];
        err  = (a > MAX_BASE);
        lat  = err ? 1 : (we ? 2 : 3);
        blk  = '0;
        if (!err) begin
          if (we) begin
            blk         = req_wdata[win*DATA_W +: DATA_W];
            exp_we_cyc  = cyc;
            exp_we_addr = ADDR_W'(a);
            exp_we_data = blk;
            for (int k = 0; k < 16; k++) ref_mem[a + k] = blk[k*32 +: 32];
          end else begin
            for (int k = 0; k < 16; k++) blk[k*32 +: 32] = ref_mem[a + k];
          end
        end
        gq.push_back('{idx: win, cyc: cyc});
        rq.push_back('{idx: win, err: err, we: we, rdata: blk, cyc: cyc + lat});
        m_busy = lat;
      end
    end
  end

  // Monitor: compare DUT outputs against model predictions mid-cycle
  initial begin : monitor
    gexp_t g;
    rexp_t r;
    logic  prev_rv;
    logic  exp_we;
    logic [N_REQ-1:0] oh;
    prev_rv = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (gnt != '0) begin
          checks++;
          if (gq.size() == 0) begin
            errors++;
            $display("FAIL gnt_unexpected: got %b at cycle %0d, none required", gnt, cyc);
          end else begin
            g  = gq.pop_front();
            oh = 2'b01 << g.idx;
            if (gnt !== oh || cyc != g.cyc) begin
              errors++;
              $display("FAIL gnt: got %b at cycle %0d, required %b at cycle %0d", gnt, cyc, oh, g.cyc);
            end
          end
        end else if (gq.size() > 0 && gq[0].cyc < cyc) begin
          checks++;
          errors++;
          g = gq.pop_front();
          $display("FAIL gnt_missing: got none, required idx %0d at cycle %0d", g.idx, g.cyc);
        end

        checks++;
        exp_we = (cyc == exp_we_cyc);
        if (mem_we !== exp_we) begin
          errors++;
          $display("FAIL mem_we: got %b at cycle %0d, required %b", mem_we, cyc, exp_we);
        end else if (exp_we && (mem_addr !== exp_we_addr || mem_wr_data !== exp_we_data)) begin
          errors++;
          $display("FAIL mem_write: got addr %0d, required addr %0d (or data differs)", mem_addr, exp_we_addr);
        end

        if (resp_valid != '0) begin
          checks++;
          if (prev_rv) begin
            errors++;
            $display("FAIL resp_back_to_back: got resp_valid in consecutive cycles at %0d, required gap", cyc);
          end
          checks++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got %b at cycle %0d, none required", resp_valid, cyc);
          end else begin
            r  = rq.pop_front();
            oh = 2'b01 << r.idx;
            if (resp_valid !== oh || resp_err !== r.err || cyc != r.cyc) begin
              errors++;
              $display("FAIL resp: got vld %b err %b cycle %0d, required vld %b err %b cycle %0d",
                       resp_valid, resp_err, cyc, oh, r.err, r.cyc);
            end else if (!r.we && !r.err && resp_rdata !== r.rdata) begin
              errors++;
              $display("FAIL resp_rdata: got %h, required %h", resp_rdata, r.rdata);
            end
          end
        end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
          checks++;
          errors++;
          r = rq.pop_front();
          $display("FAIL resp_missing: got none, required idx %0d at cycle %0d", r.idx, r.cyc);
        end
        prev_rv = (resp_valid != '0);
      end else begin
        prev_rv = 1'b0;
      end
    end
  end

  // Requester driver: present the head of each queue until it is granted
  initial begin : driver
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(negedge clock);
      if (gnt[0] && pend0.size() > 0) pend0.delete(0);
      if (gnt[1] && pend1.size() > 0) pend1.delete(0);
      if (pend0.size() > 0) begin
        req[0] = 1'b1; req_we[0] = pend0[0].we;
        req_addr[0 +: ADDR_W] = pend0[0].addr; req_wdata[0 +: DATA_W] = pend0[0].wdata;
      end else req[0] = 1'b0;
      if (pend1.size() > 0) begin
        req[1] = 1'b1; req_we[1] = pend1[0].we;
        req_addr[ADDR_W +: ADDR_W] = pend1[0].addr; req_wdata[DATA_W +: DATA_W] = pend1[0].wdata;
      end else req[1] = 1'b0;
    end
  end

  task automatic push_op(input int r, input logic we, input int addr, input logic [DATA_W-1:0] d);
    op_t o;
    o.we = we; o.addr = ADDR_W'(addr); o.wdata = d;
    if (r == 0) pend0.push_back(o);
    else pend1.push_back(o);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || gq.size() > 0 || rq.size() > 0 || m_busy != 0)
           && n < lim) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending after %0d cycles, required 0",
               pend0.size() + pend1.size() + gq.size() + rq.size(), lim);
      pend0.delete(); pend1.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_outs_zero(input string name);
    checks++;
    if (gnt !== '0 || resp_valid !== '0 || resp_err !== 1'b0 || resp_rdata !== '0 ||
        mem_addr !== '0 || mem_we !== 1'b0 || mem_wr_data !== '0) begin
      errors++;
      $display("FAIL %s: got gnt %b rv %b err %b we %b addr %0d, required all zero",
               name, gnt, resp_valid, resp_err, mem_we, mem_addr);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_blk();
    logic [DATA_W-1:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  initial begin : main
    logic [DATA_W-1:0] pat;
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_outs_zero("reset_state");
    reset = 1'b1;

    // Write base 0 with word i = i+1, then read it back
    for (int k = 0; k < 16; k++) pat[k*32 +: 32] = 32'(k + 1);
    push_op(0, 1'b1, 0, pat);
    push_op(0, 1'b0, 0, '0);
    drain(100);

    // Both requesters reading together: grants alternate
    for (int i = 0; i < 4; i++) begin
      push_op(0, 1'b0, 16 * i, '0);
      push_op(1, 1'b0, 100 + i, '0);
    end
    drain(200);

    // Top-of-array boundary
    push_op(0, 1'b1, MAX_BASE, rand_blk());
    push_op(0, 1'b0, MAX_BASE, '0);
    push_op(0, 1'b1, MAX_BASE + 1, rand_blk());
    push_op(0, 1'b0, MAX_BASE, '0);
    push_op(1, 1'b0, 511, '0);
    push_op(1, 1'b1, 511, rand_blk());
    drain(200);

    // r1 writes an A5 pattern while r0 is queued to read the same block
    pat = {64{8'hA5}};
    push_op(1, 1'b1, 32, pat);
    @(negedge clock);
    push_op(0, 1'b0, 32, '0);
    drain(100);

    // Reset during WAIT of a read: outputs clear, no response is issued
    push_op(0, 1'b0, 64, '0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!gnt[0] && n < 50);
    checks++;
    if (!gnt[0]) begin
      errors++;
      $display("FAIL reset_mid_gnt: got no grant in %0d cycles, required grant", n);
    end
    @(negedge clock);
    reset = 1'b0;
    pend0.delete(); pend1.delete();
    #1;
    check_outs_zero("reset_mid_op");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    push_op(0, 1'b0, 8, '0);
    push_op(1, 1'b0, 8, '0);
    drain(100);
    push_op(1, 1'b1, 200, rand_blk());
    drain(100);

    // Back-to-back from one requester: writes then reads
    for (int i = 0; i < 3; i++) push_op(0, 1'b1, 300 + 16 * i, rand_blk());
    for (int i = 0; i < 3; i++) push_op(0, 1'b0, 300 + 16 * i, '0);
    drain(200);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(480, 511) : $urandom_range(0, 511);
      push_op($urandom_range(0, 1), 1'($urandom_range(0, 1)), n, rand_blk());
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
